// File: rtl/riscv_core_rob_fill_arbiter_pkg.sv
// Shared ROB/writeback definitions for the out-of-order core fill path.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package riscv_core_rob_fill_arbiter_pkg;

  // ROB geometry shared with the reorder buffer itself.
  localparam int ROB_SIZE    = 16;
  localparam int ROB_SLOT_W  = $clog2(ROB_SIZE);

  // Physical register file geometry.
  localparam int PHYS_REG_W  = 5;

  // Default writeback-port configuration: ALU, MUL/DIV, memory.
  localparam int FILL_NREQ   = 3;
  localparam int FILL_DATA_W = 32;

  // Round-robin successor of a requester index among n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/riscv_core_rob_fill_arbiter_if.sv
// Writeback-port bundle: NREQ functional-unit results in, one ROB/RF fill out.
// Latency: n/a (signal bundle only).
// Backpressure: req_rdy per requester, fill_rdy from the ROB/RF consumer.
interface riscv_core_rob_fill_arbiter_if
  import riscv_core_rob_fill_arbiter_pkg::*;
#(
  parameter int NREQ   = FILL_NREQ,
  parameter int SLOT_W = ROB_SLOT_W,
  parameter int PREG_W = PHYS_REG_W,
  parameter int DATA_W = FILL_DATA_W
) ();

  localparam int SRC_W = $clog2(NREQ);

  // Functional-unit side: one lane per requester, packed lane i at [i*W +: W].
  logic [NREQ-1:0]        req_val;
  logic [NREQ-1:0]        req_rdy;
  logic [NREQ*SLOT_W-1:0] req_slot;
  logic [NREQ*PREG_W-1:0] req_preg;
  logic [NREQ*DATA_W-1:0] req_data;

  // ROB fill / register-file write side.
  logic                   fill_val;
  logic                   fill_rdy;
  logic [SLOT_W-1:0]      fill_slot;
  logic [PREG_W-1:0]      fill_preg;
  logic [DATA_W-1:0]      fill_data;
  logic [SRC_W-1:0]       fill_src;

  // Environment view: functional units plus the ROB/RF consumer.
  modport master (
    output req_val, req_slot, req_preg, req_data, fill_rdy,
    input  req_rdy, fill_val, fill_slot, fill_preg, fill_data, fill_src
  );

  // Arbiter view.
  modport slave (
    input  req_val, req_slot, req_preg, req_data, fill_rdy,
    output req_rdy, fill_val, fill_slot, fill_preg, fill_data, fill_src
  );

endinterface

// File: rtl/riscv_core_rr_arbiter.sv
// Combinational round-robin grant: first active request at or after i_ptr, with wrap.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller qualifies the grant with its own ready.
module riscv_core_rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [N-1:0]     w_grant;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;
  int               w_pos;

  // Walk the requesters from i_ptr upward, wrapping at N; first hit wins.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < N; k++) begin
      w_pos = (int'(i_ptr) + k) % N;
      if (!w_found && i_req[w_pos]) begin
        w_grant[w_pos] = 1'b1;
        w_idx          = IDX_W'(w_pos);
        w_found        = 1'b1;
      end
    end
  end

  assign o_grant = w_grant;
  assign o_idx   = w_idx;
  assign o_any   = w_found;

endmodule

// File: rtl/riscv_core_rob_fill_arbiter.sv
// Writeback arbiter: round-robin pick of one finished FU result per cycle into a registered ROB/RF fill stage.
// Latency: result accepted in cycle t is presented with fill_val=1 in cycle t+1; one result per cycle sustained.
// Backpressure: fill_val & !fill_rdy holds the output stage, drops every req_rdy and freezes the round-robin pointer.
module riscv_core_rob_fill_arbiter
  import riscv_core_rob_fill_arbiter_pkg::*;
#(
  parameter int NREQ   = FILL_NREQ,
  parameter int SLOT_W = ROB_SLOT_W,
  parameter int PREG_W = PHYS_REG_W,
  parameter int DATA_W = FILL_DATA_W
) (
  input  logic                          clk,
  input  logic                          reset,
  riscv_core_rob_fill_arbiter_if.slave  io_bus
);

  localparam int SRC_W = $clog2(NREQ);

  // Output stage and round-robin pointer.
  logic              r_fill_val;
  logic [SLOT_W-1:0] r_fill_slot;
  logic [PREG_W-1:0] r_fill_preg;
  logic [DATA_W-1:0] r_fill_data;
  logic [SRC_W-1:0]  r_fill_src;
  logic [SRC_W-1:0]  r_ptr;

  // Arbitration and handshake.
  logic [NREQ-1:0]   w_grant;
  logic [SRC_W-1:0]  w_win;
  logic              w_any;
  logic              w_out_free;
  logic              w_xfer;
  logic [SRC_W-1:0]  w_ptr_next;

  // Winner payload.
  logic [SLOT_W-1:0] w_slot;
  logic [PREG_W-1:0] w_preg;
  logic [DATA_W-1:0] w_data;

  riscv_core_rr_arbiter #(
    .N     (NREQ),
    .IDX_W (SRC_W)
  ) u_rr_arbiter (
    .i_req   (io_bus.req_val),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_win),
    .o_any   (w_any)
  );

  // The output stage can take a new result when empty or draining this cycle.
  assign w_out_free = !r_fill_val || io_bus.fill_rdy;

  // Reset gates the handshake so no requester sees an accept while it is held.
  assign w_xfer     = w_any && w_out_free && !reset;

  // Grant is one-hot, so req_rdy is one-hot or zero and only ever to a valid requester.
  assign io_bus.req_rdy = w_xfer ? w_grant : '0;

  // Priority moves to the requester just after the one served.
  assign w_ptr_next = SRC_W'(rr_next(int'(w_win), NREQ));

  // Lane select of the winning requester's payload.
  assign w_slot = io_bus.req_slot[w_win*SLOT_W +: SLOT_W];
  assign w_preg = io_bus.req_preg[w_win*PREG_W +: PREG_W];
  assign w_data = io_bus.req_data[w_win*DATA_W +: DATA_W];

  // Load on transfer (also covers drain-and-refill), else clear valid on drain; payload is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fill_val  <= 1'b0;
      r_fill_slot <= '0;
      r_fill_preg <= '0;
      r_fill_data <= '0;
      r_fill_src  <= '0;
      r_ptr       <= '0;
    end else if (w_xfer) begin
      r_fill_val  <= 1'b1;
      r_fill_slot <= w_slot;
      r_fill_preg <= w_preg;
      r_fill_data <= w_data;
      r_fill_src  <= w_win;
      r_ptr       <= w_ptr_next;
    end else if (r_fill_val && io_bus.fill_rdy) begin
      r_fill_val  <= 1'b0;
    end
  end

  assign io_bus.fill_val  = r_fill_val;
  assign io_bus.fill_slot = r_fill_slot;
  assign io_bus.fill_preg = r_fill_preg;
  assign io_bus.fill_data = r_fill_data;
  assign io_bus.fill_src  = r_fill_src;

endmodule

// File: tb/tb_riscv_core_rob_fill_arbiter.sv
// Self-checking bench for the writeback fill arbiter: directed table, hand sequences, randomized model compare.
// Latency: n/a.
// Backpressure: exercised through fill_rdy stalls.
module tb_riscv_core_rob_fill_arbiter;
  import riscv_core_rob_fill_arbiter_pkg::*;

  localparam int NREQ   = 3;
  localparam int SLOT_W = 4;
  localparam int PREG_W = 5;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  riscv_core_rob_fill_arbiter_if #(
    .NREQ(NREQ), .SLOT_W(SLOT_W), .PREG_W(PREG_W), .DATA_W(DATA_W)
  ) bus ();

  riscv_core_rob_fill_arbiter #(
    .NREQ(NREQ), .SLOT_W(SLOT_W), .PREG_W(PREG_W), .DATA_W(DATA_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic [2:0] val;
    logic       frdy;
    logic [2:0] erdy;
    logic       efv;
    logic [1:0] esrc;
    logic [1:0] pchk;  // 0: skip payload, 1: payload of esrc, 2: all zero
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int rst, input int val, input int frdy,
                              input int erdy, input int efv, input int esrc, input int pchk);
    vec_t v;
    v.rst  = rst[0];
    v.val  = val[2:0];
    v.frdy = frdy[0];
    v.erdy = erdy[2:0];
    v.efv  = efv[0];
    v.esrc = esrc[1:0];
    v.pchk = pchk[1:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_pay(input int i, input int s, input int p, input logic [31:0] d);
    bus.req_slot[i*SLOT_W +: SLOT_W] = s[SLOT_W-1:0];
    bus.req_preg[i*PREG_W +: PREG_W] = p[PREG_W-1:0];
    bus.req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.req_val  = '0;
    bus.fill_rdy = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reference model state: the output stage contents and the priority pointer.
  int          m_ptr, m_val, m_src;
  int unsigned m_slot, m_preg, m_data;
  // Randomized requesters: pending flag and held payload.
  bit          pend[NREQ];
  int unsigned ps[NREQ], pp[NREQ], pd[NREQ];
  int          waitc[NREQ];
  int          max_wait;

  initial begin
    reset        = 1'b1;
    bus.req_val  = '0;
    bus.fill_rdy = 1'b1;
    bus.req_slot = '0;
    bus.req_preg = '0;
    bus.req_data = '0;

    // Directed cycle table, one entry per cycle from reset release.
    tbl.push_back(mk(0,0,1, 0,0,0,2));  // reset state
    tbl.push_back(mk(0,7,1, 1,0,0,2));  // full contention, ptr=0
    tbl.push_back(mk(0,6,1, 2,1,0,1));
    tbl.push_back(mk(0,4,1, 4,1,1,1));
    tbl.push_back(mk(0,0,1, 0,1,2,1));
    tbl.push_back(mk(0,0,1, 0,0,2,1));  // drained, payload kept
    tbl.push_back(mk(0,2,1, 2,0,2,1));  // ptr -> 2
    tbl.push_back(mk(0,5,1, 4,1,1,1));  // wrap: 2 before 0
    tbl.push_back(mk(0,1,1, 1,1,2,1));
    tbl.push_back(mk(0,0,1, 0,1,0,1));
    tbl.push_back(mk(0,0,1, 0,0,0,1));
    tbl.push_back(mk(0,4,1, 4,0,0,1));  // ptr=1, only 2 requests
    tbl.push_back(mk(0,1,0, 0,1,2,1));  // backpressure x4, req0 pending
    tbl.push_back(mk(0,1,0, 0,1,2,1));
    tbl.push_back(mk(0,1,0, 0,1,2,1));
    tbl.push_back(mk(0,1,0, 0,1,2,1));
    tbl.push_back(mk(0,1,1, 1,1,2,1));  // drain and refill together
    tbl.push_back(mk(0,0,1, 0,1,0,1));
    tbl.push_back(mk(0,2,0, 2,0,0,1));  // empty stage accepts despite fill_rdy=0
    tbl.push_back(mk(0,0,0, 0,1,1,1));
    tbl.push_back(mk(0,0,1, 0,1,1,1));
    tbl.push_back(mk(0,0,1, 0,0,1,1));
    tbl.push_back(mk(0,7,1, 4,0,1,1));  // ptr=2
    tbl.push_back(mk(1,7,1, 0,1,2,1));  // reset mid-stream: no req_rdy
    tbl.push_back(mk(0,7,1, 1,0,0,2));  // dropped output, ptr back to 0
    tbl.push_back(mk(0,6,1, 2,1,0,1));
    tbl.push_back(mk(0,4,1, 4,1,1,1));
    tbl.push_back(mk(0,0,1, 0,1,2,1));
    tbl.push_back(mk(0,0,1, 0,0,2,1));

    do_reset();
    for (int i = 0; i < NREQ; i++) set_pay(i, i + 3, i + 10, 32'hA5A5_0000 + i);

    for (int k = 0; k < tbl.size(); k++) begin
      reset        = tbl[k].rst;
      bus.req_val  = tbl[k].val;
      bus.fill_rdy = tbl[k].frdy;
      mid();
      chk($sformatf("t%0d_req_rdy", k), 64'(bus.req_rdy), 64'(tbl[k].erdy));
      chk($sformatf("t%0d_fill_val", k), 64'(bus.fill_val), 64'(tbl[k].efv));
      chk($sformatf("t%0d_fill_src", k), 64'(bus.fill_src), 64'(tbl[k].esrc));
      if (tbl[k].pchk == 2'd1) begin
        chk($sformatf("t%0d_slot", k), 64'(bus.fill_slot), 64'(tbl[k].esrc) + 3);
        chk($sformatf("t%0d_preg", k), 64'(bus.fill_preg), 64'(tbl[k].esrc) + 10);
        chk($sformatf("t%0d_data", k), 64'(bus.fill_data), 64'h A5A5_0000 + 64'(tbl[k].esrc));
      end else if (tbl[k].pchk == 2'd2) begin
        chk($sformatf("t%0d_slot0", k), 64'(bus.fill_slot), 64'd0);
        chk($sformatf("t%0d_preg0", k), 64'(bus.fill_preg), 64'd0);
        chk($sformatf("t%0d_data0", k), 64'(bus.fill_data), 64'd0);
      end
      tick();
    end
    reset = 1'b0;

    // Single request with a distinctive payload, then confirm ptr moved to 2.
    do_reset();
    set_pay(1, 5, 12, 32'hDEAD_BEEF);
    bus.req_val  = 3'b010;
    bus.fill_rdy = 1'b1;
    mid();
    chk("single_req_rdy", 64'(bus.req_rdy), 64'b010);
    tick();
    bus.req_val = 3'b111;
    mid();
    chk("single_fill_val", 64'(bus.fill_val), 64'd1);
    chk("single_slot", 64'(bus.fill_slot), 64'd5);
    chk("single_preg", 64'(bus.fill_preg), 64'd12);
    chk("single_data", 64'(bus.fill_data), 64'h DEAD_BEEF);
    chk("single_src", 64'(bus.fill_src), 64'd1);
    chk("single_ptr2", 64'(bus.req_rdy), 64'b100);
    tick();
    // Idle for five cycles after requester 2's transfer.
    bus.req_val = 3'b000;
    for (int c = 0; c < 5; c++) begin
      mid();
      chk($sformatf("idle%0d_fill_val", c), 64'(bus.fill_val), (c == 0) ? 64'd1 : 64'd0);
      chk($sformatf("idle%0d_req_rdy", c), 64'(bus.req_rdy), 64'd0);
      tick();
    end
    bus.req_val = 3'b111;
    mid();
    chk("idle_ptr_kept", 64'(bus.req_rdy), 64'b001);
    tick();
    bus.req_val = 3'b000;
    tick();

    // Randomized traffic against the reference model.
    do_reset();
    m_ptr = 0; m_val = 0; m_src = 0; m_slot = 0; m_preg = 0; m_data = 0;
    max_wait = 0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; ps[i] = 0; pp[i] = 0; pd[i] = 0; waitc[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      int  win;
      bit  r, frdy, free;
      logic [NREQ-1:0] vals, exp_rdy;
      r    = ($urandom_range(0, 99) < 2);
      frdy = ($urandom_range(0, 99) < 70);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          ps[i] = $urandom_range(0, 15);
          pp[i] = $urandom_range(0, 31);
          pd[i] = $urandom;
        end
        vals[i] = pend[i];
        set_pay(i, int'(ps[i]), int'(pp[i]), pd[i]);
      end
      reset        = r;
      bus.req_val  = vals;
      bus.fill_rdy = frdy;

      free = (m_val == 0) || frdy;
      win  = -1;
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (win < 0 && pend[j]) win = j;
      end
      exp_rdy = '0;
      if (!r && free && win >= 0) exp_rdy[win] = 1'b1;

      mid();
      chk("rnd_req_rdy", 64'(bus.req_rdy), 64'(exp_rdy));
      chk("rnd_fill_val", 64'(bus.fill_val), 64'(m_val));
      chk("rnd_fill_src", 64'(bus.fill_src), 64'(m_src));
      chk("rnd_slot", 64'(bus.fill_slot), 64'(m_slot));
      chk("rnd_preg", 64'(bus.fill_preg), 64'(m_preg));
      chk("rnd_data", 64'(bus.fill_data), 64'(m_data));

      if (r) begin
        m_ptr = 0; m_val = 0; m_src = 0; m_slot = 0; m_preg = 0; m_data = 0;
        for (int i = 0; i < NREQ; i++) waitc[i] = 0;
      end else if (exp_rdy != '0) begin
        m_val  = 1;
        m_src  = win;
        m_slot = ps[win];
        m_preg = pp[win];
        m_data = pd[win];
        m_ptr  = (win + 1) % NREQ;
        for (int i = 0; i < NREQ; i++) begin
          if (i != win && pend[i]) begin
            waitc[i]++;
            if (waitc[i] > max_wait) max_wait = waitc[i];
          end
        end
        waitc[win] = 0;
        pend[win]  = 1'b0;
      end else if (m_val != 0 && frdy) begin
        m_val = 0;
      end
      tick();
    end
    reset = 1'b0;
    chk("rnd_fairness_bound", 64'(max_wait <= NREQ - 1), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_core_rob_fill_arbiter.md
# riscv_core_rob_fill_arbiter

Writeback-port arbiter for the out-of-order core. Up to NREQ functional units (ALU, MUL/DIV, memory) finish instructions out of order, but the reorder buffer and physical register file have one fill/writeback port. This block picks one finished result per cycle using round-robin priority. It registers the winner and drives the ROB fill port (fill slot) and the register-file write (preg, data) from that single output stage.

## Interface
- NREQ, 3: number of requesting functional units (2..8)
- SLOT_W, 4: ROB slot index width
- PREG_W, 5: physical register index width
- DATA_W, 32: result data width
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_val  in  NREQ  requester i has a finished result
- req_rdy  out  NREQ  requester i's result is accepted this cycle
- req_slot  in  NREQ*SLOT_W  ROB slot per requester; requester i occupies bits [i*SLOT_W +: SLOT_W]
- req_preg  in  NREQ*PREG_W  destination physical register per requester, same packing
- req_data  in  NREQ*DATA_W  result data per requester, same packing
- fill_val  out  1  output stage holds a valid result; drives ROB fill valid and register-file write enable
- fill_rdy  in  1  consumer accepts the output this cycle; tie high when there is no backpressure
- fill_slot  out  SLOT_W  ROB slot to mark complete
- fill_preg  out  PREG_W  register-file write address
- fill_data  out  DATA_W  register-file write data
- fill_src  out  clog2(NREQ)  index of the requester that produced the current output

## Operation
- `out_free` = !fill_val | fill_rdy. The output register can load in any cycle where out_free is 1.
- Grant: scan requesters with req_val=1, starting at pointer `ptr` and moving upward with wrap-around; the first one found wins. The grant is one-hot or zero.
- req_rdy[i] = grant[i] & out_free. req_rdy must not depend on fill_rdy of a later cycle.
- Transfer when req_val[i] & req_rdy[i]:
  - the output register loads slot, preg and data from requester i;
  - fill_src is set to i;
  - fill_val is set to 1.
- fill_val & fill_rdy with no new transfer: fill_val clears; the data fields keep their values.
- Pointer update:
  - after a transfer from requester i, ptr ← (i == NREQ-1) ? 0 : i+1;
  - ptr is unchanged when there is no transfer, including when stalled.
- A requester that is not granted holds req_val and its payload stable until it is granted. This is a requester obligation; the block has no per-requester buffering.
- Reset values:
  - ptr = 0, fill_val = 0;
  - fill_slot, fill_preg, fill_data and fill_src = 0;
  - req_rdy = 0 while reset is high.

## Timing
- Latency: a result accepted in cycle t appears with fill_val=1 in cycle t+1.
- Throughput: one result per cycle when fill_rdy=1.
- Backpressure: while fill_val=1 and fill_rdy=0:
  - all fill_* outputs are held stable;
  - all req_rdy are 0;
  - ptr is frozen.
- Drain and refill in the same cycle (fill_val & fill_rdy and a new grant): the output is replaced with no bubble.
- If all NREQ requesters assert together with fill_rdy=1 and ptr=0, they are granted in order 0,1,…,NREQ-1 on consecutive cycles.
- A requester that asserts continuously waits at most NREQ-1 grants to others before it is served.
- Reset asserted mid-operation:
  - the pending output is dropped (fill_val=0 in the next cycle);
  - ptr returns to 0;
  - no req_rdy is asserted while reset is high.

## Structure
- Shared defines header `riscvooo-CoreRobDefs.v` (used by the ROB and this block):
  - ROB slot width 4;
  - ROB size 16;
  - physical register width 5.
- Sub-module `riscv_core_rr_arbiter`: a purely combinational round-robin grant.
  - Inputs: request vector and ptr.
  - Outputs: one-hot grant and the encoded winner index.
  - It is used once here and can be reused for issue selection.
- The top level holds ptr, the output register and the handshake logic.

## Test plan
- Single request: req_val=3'b010, slot=5, preg=12, data=0xDEADBEEF, fill_rdy=1 → req_rdy=3'b010 in the same cycle; next cycle fill_val=1, slot=5, preg=12, data=0xDEADBEEF, fill_src=1; ptr becomes 2.
- Full contention: req_val=3'b111 held for 3 cycles from reset, with each requester dropping req_val after it is granted → fill_src sequence 0,1,2 on cycles 1–3; no grant is repeated.
- Wrap-around: ptr=2, req_val=3'b101 → requester 2 is granted first; ptr becomes 0; requester 0 is granted next.
- Backpressure: fill_rdy=0 for 4 cycles while fill_val=1 and requester 0 is pending → outputs stable, req_rdy=0, ptr unchanged; when fill_rdy goes to 1, the old output drains and requester 0 loads in the same cycle.
- Reset mid-stream: reset asserted for 1 cycle while fill_val=1 and req_val=3'b111 → next cycle fill_val=0 and all outputs are 0; after reset, the first grant goes to requester 0.
- Idle: req_val=0 for 5 cycles after one transfer with fill_rdy=1 → fill_val clears after 1 cycle and ptr is unchanged.
